// File: rtl/char_buffer_sequencer.sv
// Terminal command sequencer: owns the char buffer write port and the scroll offset.
// Fill commands (clears, scroll) emit one blank write per clock; single writes take one cycle.
module char_buffer_sequencer #(
    parameter int ROWS          = 24,
    parameter int COLS          = 80,
    parameter int ROW_BITS      = 5,
    parameter int COL_BITS      = 7,
    parameter int ADDR_BITS     = 11,
    parameter int PAST_LAST_ROW = ROWS * COLS,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [COL_BITS-1:0]  cmd_x,
    input  logic [ROW_BITS-1:0]  cmd_y,
    input  logic [7:0]           cmd_char,
    output logic [ADDR_BITS-1:0] first_char,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [2:0] OP_WRITE   = 3'd0;
    localparam logic [2:0] OP_CLR_EOL = 3'd1;
    localparam logic [2:0] OP_CLR_EOS = 3'd2;
    localparam logic [2:0] OP_CLR_ALL = 3'd3;
    localparam logic [2:0] OP_SCROLL  = 3'd4;

    localparam logic [ADDR_BITS:0]   COLS_W = (ADDR_BITS+1)'(COLS);
    localparam logic [ADDR_BITS:0]   PLR_W  = (ADDR_BITS+1)'(PAST_LAST_ROW);
    localparam logic [ADDR_BITS-1:0] COLS_A = ADDR_BITS'(COLS);
    localparam logic [ADDR_BITS-1:0] PLR_A  = ADDR_BITS'(PAST_LAST_ROW);
    localparam logic [ADDR_BITS-1:0] LAST_A = ADDR_BITS'(PAST_LAST_ROW - 1);
    localparam logic [COL_BITS-1:0]  COLS_X = COL_BITS'(COLS);
    localparam logic [ROW_BITS-1:0]  ROWS_Y = ROW_BITS'(ROWS);

    function automatic logic [ADDR_BITS-1:0] x_pad(input logic [COL_BITS-1:0] x);
        return {{(ADDR_BITS-COL_BITS){1'b0}}, x};
    endfunction

    function automatic logic [ADDR_BITS:0] row_offset(input logic [ROW_BITS-1:0] y);
        return (ADDR_BITS+1)'(y) * COLS_W;
    endfunction

    // first_char is a multiple of COLS, so wrapping the row base is enough; x never crosses the end.
    function automatic logic [ADDR_BITS-1:0] map_addr(input logic [ADDR_BITS-1:0] fc,
                                                      input logic [ROW_BITS-1:0]  y,
                                                      input logic [COL_BITS-1:0]  x);
        logic [ADDR_BITS:0] base;
        base = {1'b0, fc} + row_offset(y);
        if (base >= PLR_W) base = base - PLR_W;
        return base[ADDR_BITS-1:0] + x_pad(x);
    endfunction

    function automatic logic [ADDR_BITS-1:0] scroll_next(input logic [ADDR_BITS-1:0] fc);
        logic [ADDR_BITS:0] s;
        s = {1'b0, fc} + COLS_W;
        return (s == PLR_W) ? '0 : s[ADDR_BITS-1:0];
    endfunction

    function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
        return (a == LAST_A) ? '0 : a + ADDR_BITS'(1);
    endfunction

    state_t               state;
    logic [ADDR_BITS-1:0] remaining;

    logic                 coord_ok;
    logic [ADDR_BITS:0]   cmd_row_off;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic                 do_write;
    logic                 do_fill;
    logic                 do_scroll;
    logic                 do_clr_all;
    logic [ADDR_BITS-1:0] fill_addr;
    logic [ADDR_BITS-1:0] fill_len;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;

    always_comb begin
        coord_ok    = (cmd_x < COLS_X) && (cmd_y < ROWS_Y);
        cmd_row_off = row_offset(cmd_y);
        cmd_addr    = map_addr(first_char, cmd_y, cmd_x);
        do_write    = 1'b0;
        do_fill     = 1'b0;
        do_scroll   = 1'b0;
        do_clr_all  = 1'b0;
        fill_addr   = cmd_addr;
        fill_len    = '0;
        if (cmd_valid && state == IDLE) begin
            case (cmd_op)
                OP_WRITE: do_write = coord_ok;
                OP_CLR_EOL: begin
                    do_fill  = coord_ok;
                    fill_len = COLS_A - x_pad(cmd_x);
                end
                OP_CLR_EOS: begin
                    do_fill  = coord_ok;
                    fill_len = PLR_A - (cmd_row_off[ADDR_BITS-1:0] + x_pad(cmd_x));
                end
                OP_CLR_ALL: begin
                    do_fill    = 1'b1;
                    do_clr_all = 1'b1;
                    fill_addr  = '0;
                    fill_len   = PLR_A;
                end
                OP_SCROLL: begin
                    // The old top row becomes the new bottom row, so it is the one cleared.
                    do_fill   = 1'b1;
                    do_scroll = 1'b1;
                    fill_addr = first_char;
                    fill_len  = COLS_A;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            first_char <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            if (do_scroll)       first_char <= scroll_next(first_char);
            else if (do_clr_all) first_char <= '0;

            case (state)
                IDLE: begin
                    if (do_fill) begin
                        state     <= FILL;
                        wr_en     <= 1'b1;
                        wr_addr   <= fill_addr;
                        wr_data   <= BLANK_CHAR;
                        remaining <= fill_len;
                    end else if (do_write) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cmd_addr;
                        wr_data <= cmd_char;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                FILL: begin
                    // remaining counts the write currently on the port, so 1 means last.
                    if (remaining == ADDR_BITS'(1)) begin
                        state <= IDLE;
                        wr_en <= 1'b0;
                    end else begin
                        wr_addr   <= next_addr(wr_addr);
                        remaining <= remaining - ADDR_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_sequencer.sv
// Directed bench for char_buffer_sequencer: writes, scroll wrap, clears, reset mid-fill, invalid coords.
module tb_char_buffer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [7:0]  cmd_char;
    logic [10:0] first_char;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    char_buffer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_char   (cmd_char),
        .first_char (first_char),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a fill command in cycle N and checks every write of N+1..N+len plus the cycle after.
    task automatic fill(input string tag, input logic [2:0] op, input logic [6:0] x,
                        input logic [4:0] y, input int start, input int len, input int fc_exp);
        int errs;
        int a;
        chk({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_char = 8'h55; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_x = 7'd3; cmd_y = 5'd3;
        chk({tag, "_first_char"}, 32'(first_char), 32'(fc_exp));
        errs = 0;
        a = start;
        for (int i = 0; i < len; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 11'(a) || wr_data !== 8'h20 ||
                cmd_ready !== 1'b0 || busy !== 1'b1) errs++;
            a = (a == 1919) ? 0 : a + 1;
            tick();
        end
        chk({tag, "_seq_errs"}, 32'(errs), 32'd0);
        chk({tag, "_ready_post"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_wr_en_post"}, 32'(wr_en), 32'd0);
        chk({tag, "_addr_hold"}, 32'(wr_addr), 32'((a == 0) ? 1919 : a - 1));
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_x = 7'd0; cmd_y = 5'd0; cmd_char = 8'd0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_first_char", 32'(first_char), 32'd0);
        chk("rst_wr_en",      32'(wr_en),      32'd0);
        chk("rst_wr_addr",    32'(wr_addr),    32'd0);
        chk("rst_wr_data",    32'(wr_data),    32'd0);
        chk("rst_ready",      32'(cmd_ready),  32'd1);
        chk("rst_busy",       32'(busy),       32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_ready", 32'(cmd_ready), 32'd1);
            chk("idle_wr_en", 32'(wr_en),     32'd0);
        end

        // Back-to-back writes
        cmd_op = 3'd0; cmd_x = 7'd5; cmd_y = 5'd2; cmd_char = 8'h41; cmd_valid = 1'b1;
        tick();
        chk("wr1_en",    32'(wr_en),     32'd1);
        chk("wr1_addr",  32'(wr_addr),   32'd165);
        chk("wr1_data",  32'(wr_data),   32'h41);
        chk("wr1_ready", 32'(cmd_ready), 32'd1);
        cmd_x = 7'd0; cmd_y = 5'd0; cmd_char = 8'h42;
        tick();
        cmd_valid = 1'b0;
        chk("wr2_en",   32'(wr_en),   32'd1);
        chk("wr2_addr", 32'(wr_addr), 32'd0);
        chk("wr2_data", 32'(wr_data), 32'h42);
        tick();
        chk("wr_idle_en",   32'(wr_en),   32'd0);
        chk("wr_hold_data", 32'(wr_data), 32'h42);

        // Scroll up to first_char=1840, then the wrapping scroll
        for (int i = 0; i < 23; i++) fill("scroll", 3'd4, 7'd0, 5'd0, 80 * i, 80, 80 * (i + 1));
        fill("scroll_wrap", 3'd4, 7'd0, 5'd0, 1840, 80, 0);
        fill("scroll_one", 3'd4, 7'd0, 5'd0, 0, 80, 80);

        // first_char=80: row 23 base wraps to 0
        cmd_op = 3'd0; cmd_x = 7'd1; cmd_y = 5'd23; cmd_char = 8'h7a; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("wr_wrap_addr", 32'(wr_addr), 32'd1);
        chk("wr_wrap_data", 32'(wr_data), 32'h7a);
        tick();
        fill("eol_wrap", 3'd1, 7'd78, 5'd23, 78, 2, 80);
        fill("eos_full", 3'd2, 7'd0, 5'd0, 80, 1920, 80);

        for (int i = 1; i < 23; i++) fill("scroll2", 3'd4, 7'd0, 5'd0, 80 * i, 80, 80 * (i + 1));
        fill("eos_row1", 3'd2, 7'd0, 5'd1, 0, 1840, 1840);
        fill("clr_all", 3'd3, 7'd5, 5'd5, 0, 1920, 0);

        // Reset during CLR_ALL at write #500
        fill("scroll3", 3'd4, 7'd0, 5'd0, 0, 80, 80);
        cmd_op = 3'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i < 500; i++) tick();
        chk("mid_wr_en",   32'(wr_en),   32'd1);
        chk("mid_wr_addr", 32'(wr_addr), 32'd499);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_wr_en",      32'(wr_en),      32'd0);
        chk("abort_first_char", 32'(first_char), 32'd0);
        chk("abort_ready",      32'(cmd_ready),  32'd1);
        chk("abort_busy",       32'(busy),       32'd0);

        // Invalid coordinates and no-op codes
        cmd_op = 3'd0; cmd_x = 7'd80; cmd_y = 5'd0; cmd_char = 8'h41; cmd_valid = 1'b1;
        tick();
        chk("bad_x_wr_en", 32'(wr_en),     32'd0);
        chk("bad_x_ready", 32'(cmd_ready), 32'd1);
        cmd_op = 3'd1; cmd_x = 7'd0; cmd_y = 5'd24;
        tick();
        cmd_valid = 1'b0;
        chk("bad_y_wr_en", 32'(wr_en),     32'd0);
        chk("bad_y_ready", 32'(cmd_ready), 32'd1);
        fill("scroll4", 3'd4, 7'd0, 5'd0, 0, 80, 80);
        cmd_op = 3'd6; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("nop_wr_en",      32'(wr_en),      32'd0);
        chk("nop_first_char", 32'(first_char), 32'd80);
        chk("nop_ready",      32'(cmd_ready),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
